sd_cmd_seq: RTL and testbench

- Command sequencer that sits directly upstream of the SD SPI physical layer.
- Turns one SD command request (index, argument, CRC) into the SPI operation stream the PHY expects: chip select, byte transfers and response polling.
- Returns the R1 response byte or a timeout flag to the RK8E disk controller state machine.
- Works one byte at a time through the PHY's spiOP / spiTXD / spiRXD / spiDONE handshake.

---
 rtl/sd_cmd_seq_pkg.sv | 30 +++
 rtl/sd_cmd_seq.sv | 168 ++++++++++++++++
 tb/tb_sd_cmd_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_seq_pkg.sv
// Shared types for the SD command sequencer and its SPI PHY.
// Holds PHY op codes, the wire-order byte type, FSM states and constants.
package sd_cmd_seq_pkg;

   // Operations understood by the SD SPI physical layer
   typedef enum logic [1:0] {
      spiNOP = 2'd0,
      spiCSL = 2'd1,
      spiCSH = 2'd2,
      spiTR  = 2'd3
   } spiOP_t;

   // Bit 0 is the MSB, i.e. the first bit shifted onto the wire
   typedef logic [0:7] sdBYTE_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CSL  = 3'd1,
      PRE  = 3'd2,
      CMD  = 3'd3,
      RESP = 3'd4,
      POST = 3'd5,
      CSH  = 3'd6,
      FIN  = 3'd7
   } sdcmd_state_t;

   localparam sdBYTE_t SD_FILL = 8'hFF;
   localparam int SD_CMD_LEN = 6;

endpackage

// File: rtl/sd_cmd_seq.sv
// SD command sequencer: turns one command request into SPI PHY operations
// (CS, 6-byte frame, R1 polling) and returns R1 or a timeout.
// Ports: clk/rst; cmdSTART/INDEX/ARG/CRC/KEEPCS request; cmdBUSY/DONE/R1/
// TIMEOUT status; spiOP/spiTXD to the PHY, spiRXD/spiDONE from the PHY.
module sd_cmd_seq
   import sd_cmd_seq_pkg::*;
#(
   parameter int NCR_MAX = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmdSTART,
   input  logic [5:0]    cmdINDEX,
   input  logic [31:0]   cmdARG,
   input  logic [6:0]    cmdCRC,
   input  logic          cmdKEEPCS,
   output logic          cmdBUSY,
   output logic          cmdDONE,
   output sdBYTE_t       cmdR1,
   output logic          cmdTIMEOUT,
   output spiOP_t        spiOP,
   output sdBYTE_t       spiTXD,
   input  sdBYTE_t       spiRXD,
   input  logic          spiDONE
);

   sdcmd_state_t r_state;
   logic         r_wait;
   logic [2:0]   r_cnt;
   logic [7:0]   r_poll;
   logic [5:0]   r_index;
   logic [31:0]  r_arg;
   logic [6:0]   r_crc;
   logic         r_keep;

   sdBYTE_t      w_cmd_byte;
   sdBYTE_t      w_tx_byte;
   logic [7:0]   w_poll_nxt;
   logic         w_last_cmd;

   always_comb begin
      w_cmd_byte = SD_FILL;
      unique case (r_cnt)
         3'd0:    w_cmd_byte = {2'b01, r_index};
         3'd1:    w_cmd_byte = r_arg[31:24];
         3'd2:    w_cmd_byte = r_arg[23:16];
         3'd3:    w_cmd_byte = r_arg[15:8];
         3'd4:    w_cmd_byte = r_arg[7:0];
         3'd5:    w_cmd_byte = {r_crc, 1'b1};
         default: w_cmd_byte = SD_FILL;
      endcase
   end

   assign w_tx_byte  = (r_state == CMD) ? w_cmd_byte : SD_FILL;
   assign w_poll_nxt = r_poll + 8'd1;
   assign w_last_cmd = (r_cnt == 3'(SD_CMD_LEN - 1));

   // r_wait: in transfer states it marks a spiTR outstanding; in CSL/CSH
   // it marks the cycle the op is on the bus, so the following state's
   // first cycle is the mandatory spiNOP gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wait     <= 1'b0;
         r_cnt      <= 3'd0;
         r_poll     <= 8'd0;
         r_index    <= 6'd0;
         r_arg      <= 32'd0;
         r_crc      <= 7'd0;
         r_keep     <= 1'b0;
         spiOP      <= spiNOP;
         spiTXD     <= SD_FILL;
         cmdBUSY    <= 1'b0;
         cmdDONE    <= 1'b0;
         cmdR1      <= SD_FILL;
         cmdTIMEOUT <= 1'b0;
      end else begin
         spiOP   <= spiNOP;
         cmdDONE <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (cmdSTART) begin
                  r_index    <= cmdINDEX;
                  r_arg      <= cmdARG;
                  r_crc      <= cmdCRC;
                  r_keep     <= cmdKEEPCS;
                  r_poll     <= 8'd0;
                  r_wait     <= 1'b0;
                  cmdR1      <= SD_FILL;
                  cmdTIMEOUT <= 1'b0;
                  cmdBUSY    <= 1'b1;
                  r_state    <= CSL;
               end
            end
            CSL: begin
               if (!r_wait) begin
                  spiOP  <= spiCSL;
                  r_wait <= 1'b1;
               end else begin
                  r_wait  <= 1'b0;
                  r_state <= PRE;
               end
            end
            PRE, CMD, RESP: begin
               if (!r_wait) begin
                  spiOP  <= spiTR;
                  spiTXD <= w_tx_byte;
                  r_wait <= 1'b1;
               end else if (spiDONE) begin
                  r_wait <= 1'b0;
                  if (r_state == PRE) begin
                     r_cnt   <= 3'd0;
                     r_state <= CMD;
                  end else if (r_state == CMD) begin
                     if (w_last_cmd) begin
                        r_state <= RESP;
                     end else begin
                        r_cnt <= r_cnt + 3'd1;
                     end
                  end else if (spiRXD[0] == 1'b0) begin
                     cmdR1   <= spiRXD;
                     r_state <= POST;
                  end else begin
                     r_poll <= w_poll_nxt;
                     if (w_poll_nxt == 8'(NCR_MAX)) begin
                        cmdTIMEOUT <= 1'b1;
                        r_state    <= POST;
                     end
                  end
               end
            end
            POST: begin
               // A timeout always releases CS, whatever KEEPCS says
               if (r_keep && !cmdTIMEOUT) begin
                  cmdDONE <= 1'b1;
                  cmdBUSY <= 1'b0;
                  r_state <= FIN;
               end else if (!r_wait) begin
                  spiOP  <= spiTR;
                  spiTXD <= SD_FILL;
                  r_wait <= 1'b1;
               end else if (spiDONE) begin
                  r_wait  <= 1'b0;
                  r_state <= CSH;
               end
            end
            CSH: begin
               if (!r_wait) begin
                  spiOP  <= spiCSH;
                  r_wait <= 1'b1;
               end else begin
                  r_wait  <= 1'b0;
                  cmdDONE <= 1'b1;
                  cmdBUSY <= 1'b0;
                  r_state <= FIN;
               end
            end
            FIN: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Directed bench for sd_cmd_seq with a behavioural SPI PHY and MISO script.
// Checks MOSI byte stream, R1/timeout, CS handling, busy/done and reset.
module tb_sd_cmd_seq;
   import sd_cmd_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmdSTART = 1'b0;
   logic [5:0]  cmdINDEX = 6'd0;
   logic [31:0] cmdARG = 32'd0;
   logic [6:0]  cmdCRC = 7'd0;
   logic        cmdKEEPCS = 1'b0;
   logic        cmdBUSY;
   logic        cmdDONE;
   sdBYTE_t     cmdR1;
   logic        cmdTIMEOUT;
   spiOP_t      spiOP;
   sdBYTE_t     spiTXD;
   sdBYTE_t     spiRXD;
   logic        spiDONE;

   always #5 clk = ~clk;

   sd_cmd_seq #(.NCR_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .cmdSTART(cmdSTART), .cmdINDEX(cmdINDEX), .cmdARG(cmdARG),
      .cmdCRC(cmdCRC), .cmdKEEPCS(cmdKEEPCS),
      .cmdBUSY(cmdBUSY), .cmdDONE(cmdDONE), .cmdR1(cmdR1),
      .cmdTIMEOUT(cmdTIMEOUT),
      .spiOP(spiOP), .spiTXD(spiTXD), .spiRXD(spiRXD), .spiDONE(spiDONE)
   );

   // ---------------- PHY model ----------------
   logic [7:0] miso_mem [32];
   int         miso_n = 0;
   logic [7:0] mosi_mem [64];
   int         mosi_n = 0;
   int         miso_idx = 0;
   int         dly = 0;
   int         viol = 0;
   logic       outst = 1'b0;
   logic       cs_low = 1'b0;
   logic [7:0] txd_cap = 8'hFF;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         outst   <= 1'b0;
         dly     <= 0;
         spiDONE <= 1'b0;
         spiRXD  <= 8'hFF;
         cs_low  <= 1'b0;
      end else begin
         spiDONE <= 1'b0;
         if (spiOP == spiCSL) begin
            if (outst) viol <= viol + 1;
            cs_low   <= 1'b1;
            mosi_n   <= 0;
            miso_idx <= 0;
         end else if (spiOP == spiCSH) begin
            if (outst) viol <= viol + 1;
            cs_low <= 1'b0;
         end else if (spiOP == spiTR) begin
            if (outst || !cs_low) viol <= viol + 1;
            outst   <= 1'b1;
            dly     <= 3;
            txd_cap <= spiTXD;
            if (mosi_n < 64) mosi_mem[mosi_n] <= spiTXD;
            mosi_n <= mosi_n + 1;
         end else if (outst) begin
            if (spiTXD !== txd_cap) viol <= viol + 1;
            if (dly == 1) begin
               outst    <= 1'b0;
               spiDONE  <= 1'b1;
               spiRXD   <= (miso_idx < miso_n) ? miso_mem[miso_idx] : 8'hFF;
               miso_idx <= miso_idx + 1;
            end else begin
               dly <= dly - 1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;
   logic [7:0] exp_mem [64];
   int exp_n = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_miso(input logic [7:0] b, input int rep);
      for (int i = 0; i < rep; i++) begin
         miso_mem[miso_n] = b;
         miso_n++;
      end
   endtask

   task automatic add_exp(input logic [7:0] b, input int rep);
      for (int i = 0; i < rep; i++) begin
         exp_mem[exp_n] = b;
         exp_n++;
      end
   endtask

   task automatic chk_stream(input string tag);
      int bad;
      bad = 0;
      chk({tag, "_len"}, mosi_n, exp_n);
      for (int i = 0; i < exp_n && i < mosi_n && i < 64; i++)
         if (mosi_mem[i] !== exp_mem[i]) bad++;
      chk({tag, "_bytes"}, bad, 0);
   endtask

   logic cs_at_done;
   int   busy_low;

   task automatic run_cmd(input string tag, input logic [5:0] idx,
                          input logic [31:0] arg, input logic [6:0] crc,
                          input logic keep, input int spur_at,
                          input logic spur_fin);
      logic seen, injected;
      seen = 1'b0;
      injected = 1'b0;
      busy_low = 0;
      @(negedge clk);
      cmdINDEX  = idx;
      cmdARG    = arg;
      cmdCRC    = crc;
      cmdKEEPCS = keep;
      cmdSTART  = 1'b1;
      @(negedge clk);
      cmdSTART = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         if (cmdDONE) begin
            seen = 1'b1;
         end else begin
            if (!cmdBUSY) busy_low++;
            cmdSTART = 1'b0;
            if (!injected && spur_at > 0 && mosi_n == spur_at) begin
               injected  = 1'b1;
               cmdSTART  = 1'b1;
               cmdINDEX  = 6'd8;
               cmdKEEPCS = 1'b1;
            end
            @(negedge clk);
         end
      end
      cmdSTART = 1'b0;
      chk({tag, "_done_seen"}, seen, 1);
      chk({tag, "_busy_prof"}, busy_low, 0);
      chk({tag, "_busy_at_done"}, cmdBUSY, 0);
      cs_at_done = cs_low;
      if (spur_fin) cmdSTART = 1'b1;
      @(negedge clk);
      cmdSTART = 1'b0;
      chk({tag, "_done_pulse"}, cmdDONE, 0);
   endtask

   initial begin
      logic seen_tr;

      // reset state
      @(negedge clk);
      chk("rst_op", spiOP, spiNOP);
      chk("rst_txd", spiTXD, 8'hFF);
      chk("rst_busy", cmdBUSY, 0);
      chk("rst_done", cmdDONE, 0);
      chk("rst_r1", cmdR1, 8'hFF);
      chk("rst_to", cmdTIMEOUT, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // CMD0, R1=01 on second poll
      miso_n = 0; add_miso(8'hFF, 8); add_miso(8'h01, 1);
      exp_n = 0;
      add_exp(8'hFF, 1); add_exp(8'h40, 1); add_exp(8'h00, 4);
      add_exp(8'h95, 1); add_exp(8'hFF, 3);
      run_cmd("cmd0", 6'd0, 32'd0, 7'h4A, 1'b0, 0, 1'b0);
      chk_stream("cmd0");
      chk("cmd0_r1", cmdR1, 8'h01);
      chk("cmd0_to", cmdTIMEOUT, 0);
      chk("cmd0_cs", cs_at_done, 0);
      repeat (3) @(negedge clk);
      chk("cmd0_r1_hold", cmdR1, 8'h01);

      // CMD17 keep CS, R1=00 on first poll
      miso_n = 0; add_miso(8'hFF, 7); add_miso(8'h00, 1);
      exp_n = 0;
      add_exp(8'hFF, 1); add_exp(8'h51, 1); add_exp(8'h00, 2);
      add_exp(8'h12, 1); add_exp(8'h34, 1); add_exp(8'h01, 1);
      add_exp(8'hFF, 1);
      run_cmd("cmd17", 6'd17, 32'h0000_1234, 7'h00, 1'b1, 0, 1'b0);
      chk_stream("cmd17");
      chk("cmd17_r1", cmdR1, 8'h00);
      chk("cmd17_to", cmdTIMEOUT, 0);
      chk("cmd17_cs", cs_at_done, 1);

      // timeout with KEEPCS=1: 8 polls, trailing byte, CS released
      miso_n = 0;
      exp_n = 0;
      add_exp(8'hFF, 1); add_exp(8'h48, 1); add_exp(8'h00, 2);
      add_exp(8'h01, 1); add_exp(8'hAA, 1); add_exp(8'h87, 1);
      add_exp(8'hFF, 9);
      run_cmd("tmo", 6'd8, 32'h0000_01AA, 7'h43, 1'b1, 0, 1'b0);
      chk_stream("tmo");
      chk("tmo_r1", cmdR1, 8'hFF);
      chk("tmo_to", cmdTIMEOUT, 1);
      chk("tmo_cs", cs_at_done, 0);

      // starts during CMD phase and in FIN cycle are ignored
      miso_n = 0; add_miso(8'hFF, 7); add_miso(8'h01, 1);
      exp_n = 0;
      add_exp(8'hFF, 1); add_exp(8'h40, 1); add_exp(8'h00, 4);
      add_exp(8'h95, 1); add_exp(8'hFF, 2);
      run_cmd("spur", 6'd0, 32'd0, 7'h4A, 1'b0, 3, 1'b1);
      chk_stream("spur");
      chk("spur_r1", cmdR1, 8'h01);
      chk("spur_cs", cs_at_done, 0);
      repeat (20) @(negedge clk);
      chk("spur_idle_busy", cmdBUSY, 0);
      chk("spur_idle_n", mosi_n, 9);

      // 0x80 counts as a poll, 0x7F is R1
      miso_n = 0; add_miso(8'hFF, 7); add_miso(8'h80, 1);
      add_miso(8'h7F, 1);
      exp_n = 0;
      add_exp(8'hFF, 1); add_exp(8'h77, 1); add_exp(8'h00, 4);
      add_exp(8'h65, 1); add_exp(8'hFF, 3);
      run_cmd("msb", 6'd55, 32'd0, 7'h32, 1'b0, 0, 1'b0);
      chk_stream("msb");
      chk("msb_r1", cmdR1, 8'h7F);
      chk("msb_to", cmdTIMEOUT, 0);

      // R1 on the last allowed poll is still accepted
      miso_n = 0; add_miso(8'hFF, 14); add_miso(8'h00, 1);
      exp_n = 0;
      add_exp(8'hFF, 1); add_exp(8'h40, 1); add_exp(8'h00, 4);
      add_exp(8'h95, 1); add_exp(8'hFF, 8);
      run_cmd("last", 6'd0, 32'd0, 7'h4A, 1'b1, 0, 1'b0);
      chk_stream("last");
      chk("last_r1", cmdR1, 8'h00);
      chk("last_to", cmdTIMEOUT, 0);
      chk("last_cs", cs_at_done, 1);

      // asynchronous reset while a RESP transfer is issued
      miso_n = 0;
      @(negedge clk);
      cmdINDEX = 6'd0; cmdARG = 32'd0; cmdCRC = 7'h4A; cmdKEEPCS = 1'b0;
      cmdSTART = 1'b1;
      @(negedge clk);
      cmdSTART = 1'b0;
      seen_tr = 1'b0;
      for (int i = 0; i < 2000 && !seen_tr; i++) begin
         if (spiOP == spiTR && mosi_n >= 7) seen_tr = 1'b1;
         else @(negedge clk);
      end
      chk("arst_reach_resp", seen_tr, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_op", spiOP, spiNOP);
      chk("arst_txd", spiTXD, 8'hFF);
      chk("arst_busy", cmdBUSY, 0);
      chk("arst_done", cmdDONE, 0);
      chk("arst_r1", cmdR1, 8'hFF);
      chk("arst_to", cmdTIMEOUT, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      miso_n = 0; add_miso(8'hFF, 7); add_miso(8'h01, 1);
      exp_n = 0;
      add_exp(8'hFF, 1); add_exp(8'h40, 1); add_exp(8'h00, 4);
      add_exp(8'h95, 1); add_exp(8'hFF, 2);
      run_cmd("post_rst", 6'd0, 32'd0, 7'h4A, 1'b0, 0, 1'b0);
      chk_stream("post_rst");
      chk("post_rst_r1", cmdR1, 8'h01);
      chk("post_rst_cs", cs_at_done, 0);

      chk("phy_protocol", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
